// File: rtl/oled_pkg.sv
// Shared opcodes, widths and parser state for the OLED SPI responder.
package oled_pkg;
  localparam int PAGE_W = 3;
  localparam int COL_W  = 7;

  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
  localparam logic [7:0] CMD_CONTRAST  = 8'h81;
  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;

  localparam logic [7:0][7:0] ARG_OPS = {8'h81, 8'hA8, 8'hD3, 8'hD5,
                                         8'hD9, 8'hDA, 8'hDB, 8'h8D};

  typedef enum logic {CMD, ARG} parse_state_e;

  function automatic logic takes_arg(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (op == ARG_OPS[i]) hit = 1'b1;
    return hit;
  endfunction
endpackage

// File: rtl/spi_slave_shifter.sv
// Synchronises the SPI pins into sys_clk and assembles MSB-first bytes.
// OLED_SPI_SLAVE_STATS_EN adds the partial-byte (cs abort) indication.
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  input  logic       spi_dc,
  output logic       byte_done,
  output logic [7:0] data_byte,
  output logic       dc
`ifdef OLED_SPI_SLAVE_STATS_EN
  , output logic     frag
`endif
);
  logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q, dc_q;
  logic                   sck_s, mosi_s, cs_s, sck_d, rise;
  logic [6:0]             shreg;
  logic [2:0]             bit_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck_q  <= '0;
      mosi_q <= '0;
      cs_q   <= '1;
      dc_q   <= '0;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], spi_dc};
      sck_d  <= sck_s;
    end
  end

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign dc     = dc_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cs_s) begin
      bit_cnt <= '0;
    end else if (rise) begin
      shreg   <= {shreg[5:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Eighth bit is taken straight from the synchroniser so the byte is whole on this edge.
  assign byte_done = rise & ~cs_s & (bit_cnt == 3'd7);
  assign data_byte = {shreg, mosi_s};

`ifdef OLED_SPI_SLAVE_STATS_EN
  logic cs_d;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cs_d <= 1'b1;
    else            cs_d <= cs_s;
  end
  assign frag = cs_s & ~cs_d & (bit_cnt != 3'd0);
`endif
endmodule

// File: rtl/oled_spi_slave.sv
// SSD1306-style page-addressing responder: splits SPI bytes into commands/data
// and drives a framebuffer write port. OLED_SPI_SLAVE_STATS_EN adds byte counters and frame_err.
module oled_spi_slave
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_dc,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        fb_we,
  output logic [9:0]  fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        disp_on,
  output logic [7:0]  contrast
`ifdef OLED_SPI_SLAVE_STATS_EN
  , output logic [15:0] cmd_count,
  output logic [15:0] data_count,
  output logic        frame_err
`endif
);
  logic              byte_done, rx_dc;
  logic [7:0]        rx_byte, pend_op;
  logic [PAGE_W-1:0] page;
  logic [COL_W-1:0]  col;
  parse_state_e      state;

`ifdef OLED_SPI_SLAVE_STATS_EN
  logic frag;
`endif

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .spi_dc    (spi_dc),
    .byte_done (byte_done),
    .data_byte (rx_byte),
    .dc        (rx_dc)
`ifdef OLED_SPI_SLAVE_STATS_EN
    , .frag    (frag)
`endif
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_wdata     <= '0;
      disp_on      <= 1'b0;
      contrast     <= 8'h7F;
      page         <= '0;
      col          <= '0;
      pend_op      <= '0;
      state        <= CMD;
    end else begin
      byte_valid <= byte_done;
      fb_we      <= 1'b0;
      if (byte_done) begin
        byte_data    <= rx_byte;
        byte_is_data <= rx_dc;
        if (rx_dc) begin
          // Data also aborts any pending argument.
          fb_we    <= 1'b1;
          fb_addr  <= {page, col};
          fb_wdata <= rx_byte;
          col      <= (col == COL_W'(COLS-1)) ? '0 : col + 1'b1;
          state    <= CMD;
        end else if (state == ARG) begin
          if (pend_op == CMD_CONTRAST) contrast <= rx_byte;
          state <= CMD;
        end else if (rx_byte[7:3] == CMD_PAGE_BASE[7:3]) begin
          page <= rx_byte[PAGE_W-1:0] & PAGE_W'(PAGES-1);
        end else if (rx_byte[7:4] == 4'h0) begin
          col[3:0] <= rx_byte[3:0];
        end else if (rx_byte[7:3] == 5'b00010) begin
          col[COL_W-1:4] <= rx_byte[COL_W-5:0];
        end else if (rx_byte == CMD_DISP_ON) begin
          disp_on <= 1'b1;
        end else if (rx_byte == CMD_DISP_OFF) begin
          disp_on <= 1'b0;
        end else if (takes_arg(rx_byte)) begin
          pend_op <= rx_byte;
          state   <= ARG;
        end
      end
    end
  end

`ifdef OLED_SPI_SLAVE_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_count  <= '0;
      data_count <= '0;
      frame_err  <= 1'b0;
    end else begin
      if (byte_done && !rx_dc && cmd_count != 16'hFFFF)  cmd_count  <= cmd_count + 16'd1;
      if (byte_done && rx_dc && data_count != 16'hFFFF)  data_count <= data_count + 16'd1;
      if (frag) frame_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_oled_spi_slave.sv
// Directed + randomized bench for oled_spi_slave against a byte-level display model.
module tb_oled_spi_slave;
  logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic       spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0;
  logic       byte_valid, byte_is_data, fb_we, disp_on;
  logic [7:0] byte_data, fb_wdata, contrast;
  logic [9:0] fb_addr;
`ifdef OLED_SPI_SLAVE_STATS_EN
  logic [15:0] cmd_count, data_count;
  logic        frame_err;
`endif

  oled_spi_slave dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_dc(spi_dc),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .disp_on(disp_on), .contrast(contrast)
`ifdef OLED_SPI_SLAVE_STATS_EN
    , .cmd_count(cmd_count), .data_count(data_count), .frame_err(frame_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, errors = 0;
  int bv_cnt = 0, exp_bv = 0;
  logic [17:0] act_wr[$], exp_wr[$];

  // Observed bus activity; registered outputs are stable across the edge.
  always @(posedge sys_clk) begin
    if (byte_valid) bv_cnt++;
    if (fb_we) act_wr.push_back({fb_addr, fb_wdata});
  end

  // Reference model state
  int         m_page = 0, m_col = 0, m_contrast = 8'h7F, m_disp = 0;
  bit         m_arg = 0;
  int         m_pend = 0, m_cmds = 0, m_datas = 0;
  bit         m_ferr = 0;
  int         arg_ops[8] = '{8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D};
  int         cmd_pool[16] = '{8'hB0, 8'hB3, 8'hB7, 8'h00, 8'h0F, 8'h05, 8'h10, 8'h17,
                               8'hAE, 8'hAF, 8'h81, 8'hA8, 8'hD5, 8'h8D, 8'hE3, 8'h40};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_page = 0; m_col = 0; m_contrast = 8'h7F; m_disp = 0; m_arg = 0;
    m_cmds = 0; m_datas = 0; m_ferr = 0;
  endtask

  task automatic model_byte(input int b, input bit dc);
    bit is_arg_op;
    exp_bv++;
    if (dc) begin
      m_datas++;
      exp_wr.push_back(18'((m_page * 128 + m_col) * 256 + b));
      m_col = (m_col + 1) % 128;
      m_arg = 0;
    end else begin
      m_cmds++;
      if (m_arg) begin
        if (m_pend == 8'h81) m_contrast = b;
        m_arg = 0;
      end else if (b >= 8'hB0 && b <= 8'hB7) m_page = b - 8'hB0;
      else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 8'h10 && b <= 8'h17) m_col = (b - 8'h10) * 16 + (m_col % 16);
      else if (b == 8'hAF) m_disp = 1;
      else if (b == 8'hAE) m_disp = 0;
      else begin
        is_arg_op = 0;
        foreach (arg_ops[i]) if (arg_ops[i] == b) is_arg_op = 1;
        if (is_arg_op) begin m_arg = 1; m_pend = b; end
      end
    end
  endtask

  task automatic verify(input int b, input bit dc);
    logic [17:0] a, e;
    chk("byte_data", 32'(byte_data), 32'(b));
    chk("byte_is_data", 32'(byte_is_data), 32'(dc));
    chk("byte_valid_count", bv_cnt, exp_bv);
    chk("fb_write_count", act_wr.size(), exp_wr.size());
    while (act_wr.size() > 0 && exp_wr.size() > 0) begin
      a = act_wr.pop_front(); e = exp_wr.pop_front();
      chk("fb_write", 32'(a), 32'(e));
    end
    act_wr.delete(); exp_wr.delete();
    chk("disp_on", 32'(disp_on), 32'(m_disp));
    chk("contrast", 32'(contrast), 32'(m_contrast));
`ifdef OLED_SPI_SLAVE_STATS_EN
    chk("cmd_count", 32'(cmd_count), 32'(m_cmds));
    chk("data_count", 32'(data_count), 32'(m_datas));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
`endif
  endtask

  task automatic shift_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #40 spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input int b, input bit dc);
    spi_dc = dc;
    if (spi_cs) begin spi_cs = 1'b0; #30; end
    shift_bits(8'(b), 8);
    #100;
    model_byte(b, dc);
    verify(b, dc);
  endtask

  task automatic send_frag(input int b, input int n);
    if (spi_cs) begin spi_cs = 1'b0; #30; end
    shift_bits(8'(b), n);
    #40 spi_cs = 1'b1;
    #100;
    if (n > 0) m_ferr = 1;
  endtask

  initial begin
    int k, b;
    #35 sys_rst_n = 1'b1;
    #10;
    chk("rst_contrast", 32'(contrast), 32'h7F);
    chk("rst_disp_on", 32'(disp_on), 0);
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_byte_data", 32'(byte_data), 0);

    // Page/column set then data: {2, 26}, then next data lands at 27.
    send_byte(8'hB2, 0); send_byte(8'h0A, 0); send_byte(8'h11, 0);
    send_byte(8'h55, 1); send_byte(8'h66, 1);
    // Contrast argument; argument aborted by data.
    send_byte(8'h81, 0); send_byte(8'hCF, 0);
    send_byte(8'h81, 0); send_byte(8'h33, 1);
    send_byte(8'h81, 0); send_byte(8'h20, 0);
    // Column wrap within the page.
    send_byte(8'h0F, 0); send_byte(8'h17, 0);
    send_byte(8'hAA, 1); send_byte(8'hBB, 1);
    // Display on/off, unknown opcode.
    send_byte(8'hAF, 0); send_byte(8'hAE, 0); send_byte(8'hE3, 0);
    // Fragment discarded, next full byte counts.
    spi_cs = 1'b1; #40;
    send_frag(8'hFF, 5);
    send_byte(8'hB5, 0); send_byte(8'h01, 1);

    // Reset mid-byte.
    spi_cs = 1'b0; #30;
    shift_bits(8'hC3, 4);
    sys_rst_n = 1'b0; #20;
    spi_cs = 1'b1; spi_sck = 1'b0; #30;
    chk("midrst_contrast", 32'(contrast), 32'h7F);
    chk("midrst_fb_we", 32'(fb_we), 0);
    sys_rst_n = 1'b1; #40;
    model_reset();
    act_wr.delete();
    send_byte(8'hFF, 1);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 11);
      if (k <= 3)       send_byte($urandom_range(0, 255), 1);
      else if (k <= 8)  send_byte(cmd_pool[$urandom_range(0, 15)], 0);
      else if (k == 9)  send_byte($urandom_range(0, 255), 0);
      else if (k == 10) send_frag($urandom_range(0, 255), $urandom_range(1, 7));
      else begin
        b = $urandom_range(0, 255);
        send_byte(b, 0);
      end
      if ($urandom_range(0, 3) == 0) begin spi_cs = 1'b1; #40; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
